// File: rtl/pushbutton_events_pkg.sv
// Shared types for the pushbutton event controller: event kinds, the
// per-button press state, the pending-event record and a small index helper.
package pushbutton_events_pkg;

  // Two bits leave no spare code for a repeat. A repeat therefore reuses the
  // LONG code. A consumer can tell the two apart because a repeat always
  // follows a LONG from the same button with no RELEASE in between.
  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_SHORT   = 2'd1,
    EV_LONG    = 2'd2,
    EV_RELEASE = 2'd3
  } evKind_t;

  localparam evKind_t EV_REPEAT = EV_LONG;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } btnState_t;

  typedef struct packed {
    evKind_t kind;
  } event_t;

  // Next round-robin position after v, wrapping at n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/pushbutton_events_pressTimer.sv
// One button: edge detection, press-duration FSM with a saturating timer,
// and a one-deep pending event slot with a sticky overflow flag.
// PUSHBUTTON_EVENTS_REPEAT_EN: when defined, HELD emits a repeat event every
// LONG_CYCLES cycles; when undefined, HELD stays silent until release.
module pushbutton_pressTimer
  import pushbutton_events_pkg::*;
#(
  parameter int LONG_CYCLES = 1000,
  parameter int CNT_W       = $clog2(LONG_CYCLES + 1)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cg,
  input  logic    button,
  input  logic    drain,
  input  logic    clr_overflow,
  output logic    pending,
  output evKind_t kind,
  output logic    overflow
);

  localparam logic [CNT_W-1:0] HIT = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(LONG_CYCLES);

  btnState_t        state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_inc;
  logic             prev;
  event_t           slot;
  logic             rise;
  logic             fall;
  logic             timer_hit;
  logic             emit;
  event_t           emit_ev;

  // Decode edges and the event this cycle produces; fall beats the LONG timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    rise      = button & ~prev;
    fall      = ~button & prev;
    timer_hit = (timer == HIT);
    timer_inc = (timer == SAT) ? timer : timer + 1'b1;
    emit      = 1'b0;
    emit_ev   = '{kind: EV_NONE};
    case (state)
      PRESSED: begin
        if (fall) begin
          emit    = 1'b1;
          emit_ev = '{kind: EV_SHORT};
        end else if (timer_hit) begin
          emit    = 1'b1;
          emit_ev = '{kind: EV_LONG};
        end
      end
      HELD: begin
        if (fall) begin
          emit    = 1'b1;
          emit_ev = '{kind: EV_RELEASE};
        end
`ifdef PUSHBUTTON_EVENTS_REPEAT_EN
        else if (timer_hit) begin
          emit    = 1'b1;
          emit_ev = '{kind: EV_REPEAT};
        end
`endif
      end
      default: ;
    endcase
  end

  // Press FSM, timer, pending slot and sticky overflow; everything holds while gated.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      prev     <= 1'b0;
      pending  <= 1'b0;
      slot     <= '{kind: EV_NONE};
      overflow <= 1'b0;
    end else if (cg) begin
      prev <= button;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESSED;
            timer <= '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state <= IDLE;
          end else if (timer_hit) begin
            state <= HELD;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        HELD: begin
          if (fall) state <= IDLE;
`ifdef PUSHBUTTON_EVENTS_REPEAT_EN
          else if (timer_hit) timer <= '0;
`endif
          else timer <= timer_inc;
        end
        default: state <= IDLE;
      endcase

      // A new event always lands; a drain in the same cycle makes room for it.
      if (emit) begin
        pending <= 1'b1;
        slot    <= emit_ev;
      end else if (drain) begin
        pending <= 1'b0;
      end

      // Set beats clear when both happen together.
      if (emit && pending && !drain) overflow <= 1'b1;
      else if (clr_overflow)         overflow <= 1'b0;
    end
  end

  assign kind = slot.kind;

endmodule

// File: rtl/pushbutton_events.sv
// Pushbutton event controller: one press timer per button, a round-robin
// arbiter and a registered valid/ready event port.
// PUSHBUTTON_EVENTS_REPEAT_EN: when defined, held buttons also emit repeat
// events (handled inside pushbutton_pressTimer).
module pushbutton_events
  import pushbutton_events_pkg::*;
#(
  parameter  int N_BTN       = 4,
  parameter  int LONG_CYCLES = 1000,
  localparam int IDX_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int CNT_W       = $clog2(LONG_CYCLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_cg,
  input  logic [N_BTN-1:0] i_button,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_btnIdx,
  output evKind_t          o_kind,
  output logic [N_BTN-1:0] o_overflow,
  input  logic             i_clrOverflow
);

  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] drain;
  evKind_t          pend_kind [N_BTN];
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] grant;
  logic             found;
  logic             out_free;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    pushbutton_pressTimer #(
      .LONG_CYCLES(LONG_CYCLES),
      .CNT_W      (CNT_W)
    ) u_press (
      .clk         (i_clk),
      .rst_n       (i_rstn),
      .cg          (i_cg),
      .button      (i_button[b]),
      .drain       (drain[b]),
      .clr_overflow(i_clrOverflow),
      .pending     (pending[b]),
      .kind        (pend_kind[b]),
      .overflow    (o_overflow[b])
    );
  end

  // Pick the first pending button at or after rr and drain it when the port has room.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N_BTN; i++) begin
      j = int'(rr) + i;
      if (j >= N_BTN) j = j - N_BTN;
      if (!found && pending[j]) begin
        found = 1'b1;
        grant = IDX_W'(j);
      end
    end
    out_free = ~o_valid | i_ready;
    drain    = (i_cg && out_free && found) ? (N_BTN'(1) << grant) : '0;
  end

  // Output register and round-robin pointer; held steady during a stall or while gated.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid  <= 1'b0;
      o_btnIdx <= '0;
      o_kind   <= EV_NONE;
      rr       <= '0;
    end else if (i_cg && out_free) begin
      if (found) begin
        o_valid  <= 1'b1;
        o_btnIdx <= grant;
        o_kind   <= pend_kind[grant];
        rr       <= IDX_W'(wrap_inc(int'(grant), N_BTN));
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
